// File: rtl/rf_status_mp.sv
// Multi-port architectural register file with per-register busy / ROB-tag
// tracking. Lookups are combinational and see same-cycle commits (bypass)
// and older renames from the same dispatch bundle.
module rf_status_mp #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG      = 32,
  parameter int unsigned ROB_DEPTH = 32,
  parameter int unsigned N_DISP    = 2,
  parameter int unsigned N_COMMIT  = 2,
  localparam int unsigned RW       = $clog2(NREG),
  localparam int unsigned TW       = $clog2(ROB_DEPTH),
  localparam int unsigned NLK      = 2 * N_DISP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_DISP-1:0]        disp_valid,
  input  logic [N_DISP*RW-1:0]     disp_rd,
  input  logic [N_DISP*TW-1:0]     disp_tag,
  input  logic [NLK-1:0]           lk_valid,
  input  logic [NLK*RW-1:0]        lk_idx,
  input  logic [N_COMMIT-1:0]      cm_valid,
  input  logic [N_COMMIT*RW-1:0]   cm_rd,
  input  logic [N_COMMIT*TW-1:0]   cm_tag,
  input  logic [N_COMMIT*XLEN-1:0] cm_value,
  output logic [NLK-1:0]           lk_ack,
  output logic [NLK-1:0]           lk_ready,
  output logic [NLK*XLEN-1:0]      lk_data
);

  logic [XLEN-1:0] data_q [NREG];
  logic [XLEN-1:0] data_d [NREG];
  logic [TW-1:0]   tag_q  [NREG];
  logic [TW-1:0]   tag_d  [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next-state: commits write data, matching commits clear busy, renames
  // set busy/tag (later slot wins, overriding a clear), flush wipes tracking.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < N_COMMIT; k++) begin
        if (cm_valid[k] && cm_rd[k*RW +: RW] == RW'(r)) begin
          data_d[r] = cm_value[k*XLEN +: XLEN];
          if (cm_tag[k*TW +: TW] == tag_q[r]) begin
            busy_d[r] = 1'b0;
          end
        end
      end
      for (int s = 0; s < N_DISP; s++) begin
        if (!flush && disp_valid[s] && disp_rd[s*RW +: RW] == RW'(r)) begin
          busy_d[r] = 1'b1;
          tag_d[r]  = disp_tag[s*TW +: TW];
        end
      end
      if (flush) begin
        busy_d[r] = 1'b0;
        tag_d[r]  = '0;
      end
    end
    // x0 is hardwired: never written, never busy
    data_d[0] = '0;
    tag_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '{default: '0};
      tag_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  // Operand lookup: x0, older same-bundle rename, commit bypass, busy, data
  always_comb begin
    lk_ack   = '0;
    lk_ready = '0;
    lk_data  = '0;
    for (int j = 0; j < NLK; j++) begin
      logic [RW-1:0]   idx;
      logic            dhit;
      logic [TW-1:0]   dtag;
      logic            chit;
      logic [XLEN-1:0] cval;
      idx  = lk_idx[j*RW +: RW];
      dhit = 1'b0;
      dtag = '0;
      chit = 1'b0;
      cval = '0;
      for (int t = 0; t < N_DISP; t++) begin
        if (t < j / 2 && disp_valid[t] && disp_rd[t*RW +: RW] == idx) begin
          dhit = 1'b1;
          dtag = disp_tag[t*TW +: TW];
        end
      end
      for (int k = 0; k < N_COMMIT; k++) begin
        if (cm_valid[k] && cm_rd[k*RW +: RW] == idx && cm_tag[k*TW +: TW] == tag_q[idx]) begin
          chit = 1'b1;
          cval = cm_value[k*XLEN +: XLEN];
        end
      end
      if (lk_valid[j]) begin
        lk_ack[j] = 1'b1;
        if (idx == '0) begin
          lk_ready[j] = 1'b1;
        end else if (dhit) begin
          lk_data[j*XLEN +: XLEN] = XLEN'(dtag);
        end else if (busy_q[idx] && chit) begin
          lk_ready[j]             = 1'b1;
          lk_data[j*XLEN +: XLEN] = cval;
        end else if (busy_q[idx]) begin
          lk_data[j*XLEN +: XLEN] = XLEN'(tag_q[idx]);
        end else begin
          lk_ready[j]             = 1'b1;
          lk_data[j*XLEN +: XLEN] = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_status_mp.sv
// Directed bench for rf_status_mp with a queue of expected lookup results.
module tb_rf_status_mp;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int TW   = 5;
  localparam int ND   = 2;
  localparam int NC   = 2;
  localparam int NLK  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [ND-1:0]        disp_valid;
  logic [ND*RW-1:0]     disp_rd;
  logic [ND*TW-1:0]     disp_tag;
  logic [NLK-1:0]       lk_valid;
  logic [NLK*RW-1:0]    lk_idx;
  logic [NC-1:0]        cm_valid;
  logic [NC*RW-1:0]     cm_rd;
  logic [NC*TW-1:0]     cm_tag;
  logic [NC*XLEN-1:0]   cm_value;
  logic [NLK-1:0]       lk_ack;
  logic [NLK-1:0]       lk_ready;
  logic [NLK*XLEN-1:0]  lk_data;

  rf_status_mp dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_rd    (disp_rd),
    .disp_tag   (disp_tag),
    .lk_valid   (lk_valid),
    .lk_idx     (lk_idx),
    .cm_valid   (cm_valid),
    .cm_rd      (cm_rd),
    .cm_tag     (cm_tag),
    .cm_value   (cm_value),
    .lk_ack     (lk_ack),
    .lk_ready   (lk_ready),
    .lk_data    (lk_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          j;
    logic        ack;
    logic        rdy;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic clear_in();
    flush = 0; disp_valid = '0; disp_rd = '0; disp_tag = '0;
    lk_valid = '0; lk_idx = '0; cm_valid = '0; cm_rd = '0; cm_tag = '0; cm_value = '0;
  endtask

  task automatic disp(input int s, input int rd, input int tag);
    disp_valid[s] = 1'b1;
    disp_rd[s*RW +: RW]  = RW'(rd);
    disp_tag[s*TW +: TW] = TW'(tag);
  endtask

  task automatic commit(input int k, input int rd, input int tag, input logic [31:0] val);
    cm_valid[k] = 1'b1;
    cm_rd[k*RW +: RW]      = RW'(rd);
    cm_tag[k*TW +: TW]     = TW'(tag);
    cm_value[k*XLEN +: XLEN] = val;
  endtask

  // Drive lookup j and push what it must return
  task automatic look(input string name, input int j, input int idx, input logic rdy,
                      input logic [31:0] dat);
    exp_t e;
    lk_valid[j] = 1'b1;
    lk_idx[j*RW +: RW] = RW'(idx);
    e.name = name; e.j = j; e.ack = 1'b1; e.rdy = rdy; e.dat = dat;
    exp_q.push_back(e);
  endtask

  // Expect an idle lookup port to be all zero
  task automatic idle(input string name, input int j);
    exp_t e;
    e.name = name; e.j = j; e.ack = 1'b0; e.rdy = 1'b0; e.dat = '0;
    exp_q.push_back(e);
  endtask

  // Compare all pending expectations at the negedge, then advance a cycle
  task automatic step();
    exp_t e;
    logic [31:0] got;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = lk_data[e.j*XLEN +: XLEN];
      total++;
      assert (lk_ack[e.j] === e.ack) passed++;
      else $error("FAIL %s ack: got %0b want %0b", e.name, lk_ack[e.j], e.ack);
      total++;
      assert (lk_ready[e.j] === e.rdy) passed++;
      else $error("FAIL %s ready: got %0b want %0b", e.name, lk_ready[e.j], e.rdy);
      total++;
      assert (got === e.dat) passed++;
      else $error("FAIL %s data: got 0x%0h want 0x%0h", e.name, got, e.dat);
    end
    @(posedge clk);
    #1;
    clear_in();
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and x0 rules
    look("rst_x5", 0, 5, 1'b1, 32'h0);
    look("rst_x7", 1, 7, 1'b1, 32'h0);
    disp(0, 0, 3);
    look("x0_disp", 2, 0, 1'b1, 32'h0);
    idle("idle3", 3);
    step();
    look("x0_after", 0, 0, 1'b1, 32'h0);
    step();

    // Rename, then commit bypass, then busy cleared
    disp(0, 7, 9);
    look("x7_prior", 0, 7, 1'b1, 32'h0);
    step();
    look("x7_busy", 0, 7, 1'b0, 32'd9);
    step();
    commit(0, 7, 9, 32'hDEAD);
    look("x7_bypass", 0, 7, 1'b1, 32'hDEAD);
    step();
    look("x7_data", 1, 7, 1'b1, 32'hDEAD);
    step();

    // Same-bundle rename visibility
    disp(0, 4, 2);
    look("x4_src0", 0, 4, 1'b1, 32'h0);
    look("x4_src2", 2, 4, 1'b0, 32'd2);
    look("x4_src3", 3, 4, 1'b0, 32'd2);
    step();
    look("x4_busy", 0, 4, 1'b0, 32'd2);
    step();

    // Re-rename and a stale commit
    disp(0, 3, 1);
    step();
    disp(1, 3, 6);
    look("x3_t1", 0, 3, 1'b0, 32'd1);
    step();
    commit(1, 3, 1, 32'h11);
    look("x3_stale", 0, 3, 1'b0, 32'd6);
    step();
    look("x3_t6", 0, 3, 1'b0, 32'd6);
    step();

    // Both slots rename x11: later slot wins
    disp(0, 11, 5);
    disp(1, 11, 7);
    step();
    look("x11_win", 1, 11, 1'b0, 32'd7);
    step();

    // x8: dispatch overrides matching commit; same-rd commits
    disp(0, 8, 10);
    step();
    commit(0, 8, 10, 32'h80);
    disp(0, 8, 12);
    look("x8_byp", 0, 8, 1'b1, 32'h80);
    step();
    look("x8_t12", 0, 8, 1'b0, 32'd12);
    step();
    commit(0, 8, 12, 32'hA);
    commit(1, 8, 12, 32'hB);
    look("x8_byp2", 0, 8, 1'b1, 32'hB);
    step();
    look("x8_data", 0, 8, 1'b1, 32'hB);
    step();

    // Flush with concurrent commit and dispatch
    flush = 1'b1;
    commit(0, 9, 0, 32'h55);
    disp(0, 10, 4);
    look("x9_flcyc", 0, 9, 1'b1, 32'h0);
    step();
    look("x9_fl", 0, 9, 1'b1, 32'h55);
    look("x10_fl", 1, 10, 1'b1, 32'h0);
    look("x3_fl", 2, 3, 1'b1, 32'h11);
    look("x4_fl", 3, 4, 1'b1, 32'h0);
    step();
    look("x11_fl", 0, 11, 1'b1, 32'h0);
    disp(0, 12, 3);
    step();

    // Mid-stream reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    look("rst2_x7", 0, 7, 1'b1, 32'h0);
    look("rst2_x8", 1, 8, 1'b1, 32'h0);
    look("rst2_x12", 2, 12, 1'b1, 32'h0);
    look("rst2_x3", 3, 3, 1'b1, 32'h0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
